// File: rtl/div_32b_seq.sv
// rtl/div_32b_seq.sv - sequential unsigned 32-bit restoring divider
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       launch request, sampled only in IDLE
//   dividend    unsigned dividend, captured on the accepting edge
//   divisor     unsigned divisor, captured on the accepting edge
//   busy        high while a division is in progress or being presented
//   done        one-cycle pulse, results valid while high
//   quotient    unsigned quotient, held until the next accepted start
//   remainder   unsigned remainder, held until the next accepted start
//   div_by_zero set when the last accepted divisor was zero
module div_32b_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  // Partial remainder is always below the divisor, so its top bit is
  // never set and only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [5:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_r_next;

  // Shift the next dividend bit into the partial remainder.
  assign w_rs    = {r_r, r_q[WIDTH-1]};
  assign w_sub_b = ~{1'b0, r_d};

  // Ripple-carry subtractor: Rs + ~D + 1, bit-level full adders.
  always_comb begin
    logic [WIDTH:0] c;
    c    = '0;
    c[0] = 1'b1;
    w_t  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_t[i]   = w_rs[i] ^ w_sub_b[i] ^ c[i];
      c[i+1]   = (w_rs[i] & w_sub_b[i]) | (c[i] & (w_rs[i] ^ w_sub_b[i]));
    end
    w_t[WIDTH] = w_rs[WIDTH] ^ w_sub_b[WIDTH] ^ c[WIDTH];
  end

  // A clear sign bit means the divisor fit: keep the difference and
  // record a 1; otherwise restore the shifted remainder and record a 0.
  assign w_q_next = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
  assign w_r_next = w_t[WIDTH] ? w_rs[WIDTH-1:0] : w_t[WIDTH-1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == 6'd31) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Handshake outputs are registered from the current state, so they
      // trail the state register by one cycle.
      r_busy  <= (r_state != S_IDLE);
      r_done  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_q    <= dividend;
              r_r    <= '0;
              r_d    <= divisor;
              r_cnt  <= '0;
              r_quot <= '0;
              r_rem  <= '0;
              r_dbz  <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 6'd1;
          // The final iteration and the result capture share one edge.
          if (r_cnt == 6'd31) begin
            r_quot <= w_q_next;
            r_rem  <= w_r_next;
            r_dbz  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_32b_seq.sv
// tb/tb_div_32b_seq.sv - self-checking bench for div_32b_seq
module tb_div_32b_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass = 0;

  div_32b_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Timeline model: each accepted launch schedules busy/done windows and
  // results by edge number; quotient/remainder come from plain / and %.
  int          ecount = 0;
  bit          m_seen_reset = 0;
  int          m_next_accept = 0;
  int          m_busy_first = 1;
  int          m_busy_last = 0;
  int          m_done_at = -1;
  int          m_valid_from = 0;
  logic [31:0] m_q = '0;
  logic [31:0] m_r = '0;
  logic        m_z = 1'b0;

  always @(posedge clk) begin
    ecount <= ecount + 1;
    if (reset) begin
      m_seen_reset  <= 1;
      m_busy_first  <= 1;
      m_busy_last   <= 0;
      m_done_at     <= -1;
      m_valid_from  <= 0;
      m_q           <= '0;
      m_r           <= '0;
      m_z           <= 1'b0;
      m_next_accept <= ecount + 2;
    end else if (m_seen_reset && start && (ecount + 1 >= m_next_accept)) begin
      if (divisor == 0) begin
        m_busy_first  <= ecount + 2;
        m_busy_last   <= ecount + 2;
        m_done_at     <= ecount + 2;
        m_next_accept <= ecount + 3;
        m_valid_from  <= ecount + 1;
        m_q           <= 32'hFFFF_FFFF;
        m_r           <= dividend;
        m_z           <= 1'b1;
      end else begin
        m_busy_first  <= ecount + 2;
        m_busy_last   <= ecount + 34;
        m_done_at     <= ecount + 34;
        m_next_accept <= ecount + 35;
        m_valid_from  <= ecount + 33;
        m_q           <= dividend / divisor;
        m_r           <= dividend % divisor;
        m_z           <= 1'b0;
      end
    end
  end

  // Compare every cycle once the model has been reset.
  always @(negedge clk) begin
    if (m_seen_reset) begin
      chk("busy", 32'(busy), 32'(ecount >= m_busy_first && ecount <= m_busy_last));
      chk("done", 32'(done), 32'(ecount == m_done_at));
      chk("quotient", quotient, (ecount >= m_valid_from) ? m_q : 32'd0);
      chk("remainder", remainder, (ecount >= m_valid_from) ? m_r : 32'd0);
      chk("div_by_zero", 32'(div_by_zero), 32'((ecount >= m_valid_from) ? m_z : 1'b0));
    end
  end

  int e_acc;

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    e_acc = ecount;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        t = ecount;
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_lit(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input int lat);
    int t;
    launch(a, b);
    wait_done(t);
    chk({nm, "_lat"}, 32'(t - e_acc), 32'(lat));
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_z"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int e1;
    int n_done;
    logic [31:0] a;
    logic [31:0] b;
    longint recon;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);

    run_lit("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_lit("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_lit("d5_10", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 33);
    run_lit("dmsb_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
    run_lit("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
    run_lit("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // start pulse with new operands during CALC must be ignored
    launch(32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 32'd50;
    divisor = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(t);
    chk("ign_lat", 32'(t - e_acc), 32'd33);
    chk("ign_q", quotient, 32'd14);
    chk("ign_r", remainder, 32'd2);

    // reset in the middle of CALC discards the division
    launch(32'd100, 32'd7);
    while (ecount < e_acc + 10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_quot", quotient, 32'd0);
    chk("mid_rst_rem", remainder, 32'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("mid_rst_no_done", 32'(n_done), 32'd0);
    run_lit("d81_9", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33);

    // start held high relaunches at the first IDLE edge
    @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 32'd20;
    divisor = 32'd6;
    @(posedge clk);
    #1 e1 = ecount;
    wait_done(t);
    chk("b2b_lat1", 32'(t - e1), 32'd33);
    chk("b2b_q1", quotient, 32'd3);
    chk("b2b_r1", remainder, 32'd2);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(t);
    chk("b2b_lat2", 32'(t - e1), 32'd67);
    chk("b2b_q2", quotient, 32'd3);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 255));
        2: b = $urandom >> $urandom_range(0, 31);
        default: begin
          b = 32'($urandom_range(1, 1000));
          a = 32'($urandom_range(0, 5000));
        end
      endcase
      if (b == 0) b = 32'd1;
      launch(a, b);
      wait_done(t);
      recon = longint'(quotient) * longint'(b) + longint'(remainder);
      chk("rand_identity", 32'(recon == longint'(a)), 32'd1);
      chk("rand_rem_lt", 32'(remainder < b), 32'd1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
